irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Edge-triggered interrupt controller. Synchronizes N_SRC raw
//               interrupt lines, latches rising edges into a pending register,
//               masks them, selects the lowest-index request and hands it to
//               CP0 through a three-state IDLE/REQ/SERVICE handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic             mask_we_i,
    input  logic [N_SRC-1:0] mask_wdata_i,
    output logic [N_SRC-1:0] mask_rdata_o,
    input  logic             ir_ack_i,
    input  logic             eret_i,
    output logic             ir_out_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic [N_SRC-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [N_SRC-1:0] C_ONE = {{(N_SRC-1){1'b0}}, 1'b1};

    // Synchronizer (s1, s2) and history flop (s3)
    logic [N_SRC-1:0] s1_q;
    logic [N_SRC-1:0] s2_q;
    logic [N_SRC-1:0] s3_q;

    // Pending and mask registers with their next-state values
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mask_d;

    // Handshake FSM and its registered outputs
    state_t           state_q;
    logic             ir_out_q;
    logic [ID_W-1:0]  irq_id_q;

    // Combinational helpers
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_ack_clr;
    logic [ID_W-1:0]  w_winner;
    logic             w_req_any;
    logic             w_ack_take;

    // Two-flop synchronizer plus history flop; s3 holds the previous s2 value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq_src_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // A rising edge is seen once, in the cycle s2 is high and s3 still low
    assign w_rise    = s2_q & ~s3_q;

    // Only enabled pending bits compete for service
    assign w_req     = pending_q & mask_q;
    assign w_req_any = |w_req;

    // Lowest set index wins: scan downwards so the last hit is the smallest
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // Ack is only honoured while requesting; it clears the winning bit, and
    // the AND with w_req keeps an ack with no live request from clearing bit 0
    assign w_ack_take = (state_q == ST_REQ) && ir_ack_i;
    assign w_ack_clr  = w_ack_take ? (w_req & (C_ONE << w_winner)) : '0;

    // A new edge on the same bit as an ack-clear must survive, so set is ORed last
    assign pending_d  = (pending_q & ~w_ack_clr) | w_rise;

    // Mask writes never touch pending
    assign mask_d     = mask_we_i ? mask_wdata_i : mask_q;

    // Pending and mask storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Request/service handshake; ir_out and irq_id are registered alongside state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ir_out_q <= 1'b0;
            irq_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req_any) begin
                        state_q  <= ST_REQ;
                        ir_out_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ir_ack_i) begin
                        state_q  <= ST_SERVICE;
                        ir_out_q <= 1'b0;
                        irq_id_q <= w_winner;
                    end else if (!w_req_any) begin
                        state_q  <= ST_IDLE;
                        ir_out_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    // No nesting: further edges just accumulate in pending
                    if (eret_i) begin
                        state_q  <= ST_IDLE;
                        ir_out_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ir_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign mask_rdata_o = mask_q;
    assign pending_o    = pending_q;
    assign ir_out_o     = ir_out_q;
    assign irq_id_o     = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl: directed scenarios followed
//               by randomized traffic, compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_src;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic [N-1:0]  mask_rdata;
    logic          ir_ack;
    logic          eret;
    logic          ir_out;
    logic [IW-1:0] irq_id;
    logic [N-1:0]  pending;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src_i    (irq_src),
        .mask_we_i    (mask_we),
        .mask_wdata_i (mask_wdata),
        .mask_rdata_o (mask_rdata),
        .ir_ack_i     (ir_ack),
        .eret_i       (eret),
        .ir_out_o     (ir_out),
        .irq_id_o     (irq_id),
        .pending_o    (pending)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: line samples seen at the last three edges, newest first
    logic [N-1:0] m_hist [3];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_mask;
    int           m_phase;   // 0 idle, 1 requesting, 2 servicing
    int           m_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_hist[2] = '0;
        m_pend    = '0;
        m_mask    = '0;
        m_phase   = 0;
        m_id      = 0;
    endtask

    // Advance the model across one clock edge, then compare after the edge
    task automatic step();
        logic [N-1:0] rise;
        logic [N-1:0] req;
        logic [N-1:0] clr;
        int           nphase;
        // a line change sampled two edges ago becomes visible at this edge
        rise   = m_hist[1] & ~m_hist[2];
        req    = m_pend & m_mask;
        clr    = '0;
        nphase = m_phase;
        if (m_phase == 0) begin
            if (req != 0) nphase = 1;
        end else if (m_phase == 1) begin
            if (ir_ack) begin
                nphase = 2;
                m_id   = lowest(req);
                if (req != 0) clr[m_id] = 1'b1;
            end else if (req == 0) begin
                nphase = 0;
            end
        end else begin
            if (eret) nphase = 0;
        end
        m_pend    = (m_pend & ~clr) | rise;
        if (mask_we) m_mask = mask_wdata;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq_src;
        m_phase   = nphase;
        @(posedge clk);
        #1;
        check("ir_out",  32'(ir_out),     32'(m_phase == 1));
        check("irq_id",  32'(irq_id),     32'(m_id));
        check("pending", 32'(pending),    32'(m_pend));
        check("mask",    32'(mask_rdata), 32'(m_mask));
    endtask

    task automatic cyc(input logic ack, input logic er, input logic we, input logic [N-1:0] wd);
        ir_ack     = ack;
        eret       = er;
        mask_we    = we;
        mask_wdata = wd;
        step();
        ir_ack     = 1'b0;
        eret       = 1'b0;
        mask_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_src    = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        ir_ack     = 1'b0;
        eret       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ir_out",  32'(ir_out),     32'h0);
        check("rst_irq_id",  32'(irq_id),     32'h0);
        check("rst_pending", 32'(pending),    32'h0);
        check("rst_mask",    32'(mask_rdata), 32'h0);
        rst_n = 1'b1;

        // Single source, latency and ack
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        irq_src = 8'h20;
        idle(3);
        check("s5_pending_k2", 32'(pending), 32'h20);
        check("s5_irout_k2",   32'(ir_out),  32'h0);
        idle(1);
        check("s5_irout_k3",   32'(ir_out),  32'h1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("s5_id",         32'(irq_id),  32'h5);
        check("s5_pending_ack",32'(pending), 32'h00);
        check("s5_irout_ack",  32'(ir_out),  32'h0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        idle(2);

        // Two simultaneous sources, priority order
        irq_src = 8'h44;
        idle(4);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("pri_id_first",  32'(irq_id),  32'h2);
        check("pri_pending",   32'(pending), 32'h40);
        cyc(1'b0, 1'b1, 1'b0, '0);
        idle(1);
        check("pri_reassert",  32'(ir_out),  32'h1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("pri_id_second", 32'(irq_id),  32'h6);
        cyc(1'b0, 1'b1, 1'b0, '0);

        // Masked source enabled later
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        irq_src = 8'h08;
        idle(4);
        check("msk_pending",   32'(pending), 32'h08);
        check("msk_irout_off", 32'(ir_out),  32'h0);
        cyc(1'b0, 1'b0, 1'b1, 8'h08);
        idle(1);
        check("msk_irout_on",  32'(ir_out),  32'h1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);

        // Mask removed while requesting
        cyc(1'b0, 1'b0, 1'b1, 8'h10);
        irq_src = 8'h10;
        idle(4);
        check("drop_req",      32'(ir_out),  32'h1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);
        check("drop_irout",    32'(ir_out),  32'h0);
        check("drop_pending",  32'(pending), 32'h10);

        // Edge and spurious ack during service
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("svc_id4",       32'(irq_id),  32'h4);
        irq_src = 8'h12;
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        idle(1);
        check("svc_pending",   32'(pending), 32'h02);
        check("svc_irout",     32'(ir_out),  32'h0);
        check("svc_id_hold",   32'(irq_id),  32'h4);
        cyc(1'b0, 1'b1, 1'b0, '0);
        idle(1);
        check("svc_reassert",  32'(ir_out),  32'h1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check("svc_id1",       32'(irq_id),  32'h1);
        cyc(1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset while requesting
        irq_src = 8'h00;
        idle(3);
        irq_src = 8'h01;
        idle(4);
        check("ar_in_req",     32'(ir_out),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ir_out",     32'(ir_out),     32'h0);
        check("ar_pending",    32'(pending),    32'h0);
        check("ar_mask",       32'(mask_rdata), 32'h0);
        check("ar_irq_id",     32'(irq_id),     32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        irq_src = 8'h00;
        rst_n   = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] flip;
            flip = '0;
            for (int b = 0; b < N; b++) begin
                flip[b] = ($urandom_range(0, 7) == 0);
            end
            irq_src ^= flip;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0, N'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
